// File: rtl/wb_sequencer_pkg.sv
// Shared definitions for the writeback sequencer: state encoding, register
// indices and the write-port filter, which the hazard unit can reuse.
package wb_sequencer_pkg;

    localparam int DW_DEF   = 32;
    localparam int AW_DEF   = 5;
    localparam int REG_ZERO = 0;
    localparam int REG_PC   = 30;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRI  = 2'd1,
        SEC  = 2'd2
    } wb_state_t;

    // True when a write to dest may reach the register file.
    function automatic logic wb_dest_ok(input int unsigned dest,
                                        input int unsigned pc_reg);
        return (dest != REG_ZERO) && (dest != pc_reg);
    endfunction

endpackage

// File: rtl/wb_sequencer_if.sv
// MEM-to-WB bus of the writeback sequencer, including the register-file write
// port, the retired counter and the bypass outputs.
interface wb_sequencer_if
    import wb_sequencer_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
);
    logic          mem_valid;
    logic          mem_wr_en;
    logic          mem_is_load;
    logic [AW-1:0] mem_rd;
    logic [DW-1:0] mem_result;
    logic [DW-1:0] mem_load_data;
    logic          mem_has_second;
    logic [AW-1:0] mem_rd2;
    logic [DW-1:0] mem_data2;

    logic          stall_mem;
    logic [AW-1:0] R_dest;
    logic [DW-1:0] WBData;
    logic          WR;
    logic [31:0]   retired;
    logic          fwd_valid;
    logic [AW-1:0] fwd_dest;
    logic [DW-1:0] fwd_data;

    // MEM stage side.
    modport master (
        output mem_valid, mem_wr_en, mem_is_load, mem_rd, mem_result,
               mem_load_data, mem_has_second, mem_rd2, mem_data2,
        input  stall_mem, R_dest, WBData, WR, retired,
               fwd_valid, fwd_dest, fwd_data
    );

    // Writeback sequencer side.
    modport slave (
        input  mem_valid, mem_wr_en, mem_is_load, mem_rd, mem_result,
               mem_load_data, mem_has_second, mem_rd2, mem_data2,
        output stall_mem, R_dest, WBData, WR, retired,
               fwd_valid, fwd_dest, fwd_data
    );
endinterface

// File: rtl/wb_sequencer.sv
// Writeback sequencer: drives the single register-file write port, splitting
// dual-write instructions over two cycles. Optional bypass outputs: WB_FWD_EN.
module wb_sequencer
    import wb_sequencer_pkg::*;
#(
    parameter int DW     = DW_DEF,
    parameter int AW     = AW_DEF,
    parameter int PC_REG = REG_PC
) (
    input  logic           clk,
    input  logic           reset,
    wb_sequencer_if.slave  bus
);

    wb_state_t     r_state;
    wb_state_t     w_next_state;

    logic          r_wr_en;
    logic          r_is_load;
    logic [AW-1:0] r_rd;
    logic [DW-1:0] r_result;
    logic [DW-1:0] r_load_data;
    logic          r_has_second;
    logic [AW-1:0] r_rd2;
    logic [DW-1:0] r_data2;
    logic [31:0]   r_retired;

    logic          w_stall;
    logic          w_accept;
    logic          w_retire;
    logic          w_wr;
    logic [AW-1:0] w_dest;
    logic [DW-1:0] w_data;

    assign w_stall  = (r_state == PRI) && r_has_second;
    assign w_accept = bus.mem_valid && !w_stall;
    assign w_retire = ((r_state == PRI) && !r_has_second) || (r_state == SEC);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        w_next_state = r_state;
        case (r_state)
            IDLE:    w_next_state = w_accept ? PRI : IDLE;
            PRI:     if (r_has_second) w_next_state = SEC;
                     else              w_next_state = w_accept ? PRI : IDLE;
            SEC:     w_next_state = w_accept ? PRI : IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        w_wr   = 1'b0;
        w_dest = '0;
        w_data = '0;
        case (r_state)
            PRI: begin
                w_dest = r_rd;
                w_data = r_is_load ? r_load_data : r_result;
                w_wr   = r_wr_en && wb_dest_ok(32'(r_rd), PC_REG);
            end
            SEC: begin
                w_dest = r_rd2;
                w_data = r_data2;
                w_wr   = wb_dest_ok(32'(r_rd2), PC_REG);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            r_state   <= IDLE;
            r_retired <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_retire) r_retired <= r_retired + 32'd1;
        end
    end

    // NOTE: the latched instruction is not reset; the port is gated by state, so stale contents never reach it.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_wr_en      <= bus.mem_wr_en;
            r_is_load    <= bus.mem_is_load;
            r_rd         <= bus.mem_rd;
            r_result     <= bus.mem_result;
            r_load_data  <= bus.mem_load_data;
            r_has_second <= bus.mem_has_second;
            r_rd2        <= bus.mem_rd2;
            r_data2      <= bus.mem_data2;
        end
    end

    assign bus.stall_mem = w_stall;
    assign bus.WR        = w_wr;
    assign bus.R_dest    = w_dest;
    assign bus.WBData    = w_data;
    assign bus.retired   = r_retired;

`ifdef WB_FWD_EN
    assign bus.fwd_valid = w_wr;
    assign bus.fwd_dest  = w_dest;
    assign bus.fwd_data  = w_data;
`else
    assign bus.fwd_valid = 1'b0;
    assign bus.fwd_dest  = '0;
    assign bus.fwd_data  = '0;
`endif

endmodule

// File: tb/tb_wb_sequencer.sv
// Bench for wb_sequencer: directed scenarios with literal expectations, then
// random traffic compared every cycle against a write-queue model.
module tb_wb_sequencer;

    logic clk;
    logic reset;

    wb_sequencer_if #(.DW(32), .AW(5)) bus ();

    wb_sequencer #(.DW(32), .AW(5), .PC_REG(30)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: each accepted instruction becomes one or two port cycles in a queue;
    // the head is what the write port shows this cycle.
    typedef struct {
        logic [4:0]  dest;
        logic [31:0] data;
        bit          we;
        bit          last;
    } wr_t;

    wr_t         q[$];
    logic [31:0] m_retired;
    bit          model_ready = 1'b0;

    always @(posedge clk) begin
        bit  acc;
        wr_t e;
        if (reset) begin
            q.delete();
            m_retired   = 32'd0;
            model_ready = 1'b1;
        end else begin
            acc = bus.mem_valid && !(q.size() > 1);
            if (q.size() > 0) begin
                if (q[0].last) m_retired = m_retired + 32'd1;
                void'(q.pop_front());
            end
            if (acc) begin
                e.dest = bus.mem_rd;
                e.data = bus.mem_is_load ? bus.mem_load_data : bus.mem_result;
                e.we   = bus.mem_wr_en;
                e.last = !bus.mem_has_second;
                q.push_back(e);
                if (bus.mem_has_second) begin
                    e.dest = bus.mem_rd2;
                    e.data = bus.mem_data2;
                    e.we   = 1'b1;
                    e.last = 1'b1;
                    q.push_back(e);
                end
            end
        end
    end

    always @(negedge clk) begin
        logic        e_wr;
        logic [4:0]  e_dest;
        logic [31:0] e_data;
        if (model_ready) begin
            e_wr   = 1'b0;
            e_dest = 5'd0;
            e_data = 32'd0;
            if (q.size() > 0) begin
                e_dest = q[0].dest;
                e_data = q[0].data;
                e_wr   = q[0].we && (q[0].dest != 5'd0) && (q[0].dest != 5'd30);
            end
            check("stall_mem", 64'(bus.stall_mem), 64'(q.size() > 1));
            check("WR",        64'(bus.WR),        64'(e_wr));
            check("R_dest",    64'(bus.R_dest),    64'(e_dest));
            check("WBData",    64'(bus.WBData),    64'(e_data));
            check("retired",   64'(bus.retired),   64'(m_retired));
`ifdef WB_FWD_EN
            check("fwd_valid", 64'(bus.fwd_valid), 64'(e_wr));
            check("fwd_dest",  64'(bus.fwd_dest),  64'(e_dest));
            check("fwd_data",  64'(bus.fwd_data),  64'(e_data));
`else
            check("fwd_valid", 64'(bus.fwd_valid), 64'd0);
            check("fwd_dest",  64'(bus.fwd_dest),  64'd0);
            check("fwd_data",  64'(bus.fwd_data),  64'd0);
`endif
        end
    end

    task automatic drive(input bit v, input bit we, input bit ld, input logic [4:0] rd,
                         input logic [31:0] res, input logic [31:0] ldd, input bit h2,
                         input logic [4:0] rd2, input logic [31:0] d2);
        bus.mem_valid      = v;
        bus.mem_wr_en      = we;
        bus.mem_is_load    = ld;
        bus.mem_rd         = rd;
        bus.mem_result     = res;
        bus.mem_load_data  = ldd;
        bus.mem_has_second = h2;
        bus.mem_rd2        = rd2;
        bus.mem_data2      = d2;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        idle();
        repeat (2) @(negedge clk);
        check("rst_stall",   64'(bus.stall_mem), 64'd0);
        check("rst_WR",      64'(bus.WR),        64'd0);
        check("rst_R_dest",  64'(bus.R_dest),    64'd0);
        check("rst_WBData",  64'(bus.WBData),    64'd0);
        check("rst_retired", 64'(bus.retired),   64'd0);
        reset = 1'b0;

        // Single ALU op.
        drive(1'b1, 1'b1, 1'b0, 5'd5, 32'h1234, 32'h0, 1'b0, 5'd0, 32'h0);
        @(negedge clk);
        check("alu_WR",     64'(bus.WR),     64'd1);
        check("alu_R_dest", 64'(bus.R_dest), 64'd5);
        check("alu_WBData", 64'(bus.WBData), 64'h1234);
        idle();
        @(negedge clk);
        check("alu_retired", 64'(bus.retired), 64'd1);

        // Load with base update.
        drive(1'b1, 1'b1, 1'b1, 5'd7, 32'h5555, 32'hDEADBEEF, 1'b1, 5'd3, 32'h104);
        @(negedge clk);
        check("ld_pri_stall",  64'(bus.stall_mem), 64'd1);
        check("ld_pri_R_dest", 64'(bus.R_dest),    64'd7);
        check("ld_pri_WBData", 64'(bus.WBData),    64'hDEADBEEF);
        check("ld_pri_WR",     64'(bus.WR),        64'd1);
        idle();
        @(negedge clk);
        check("ld_sec_stall",  64'(bus.stall_mem), 64'd0);
        check("ld_sec_R_dest", 64'(bus.R_dest),    64'd3);
        check("ld_sec_WBData", 64'(bus.WBData),    64'h104);
        check("ld_sec_WR",     64'(bus.WR),        64'd1);
        @(negedge clk);
        check("ld_retired", 64'(bus.retired), 64'd2);

        // Filtered destinations r0 and r30.
        drive(1'b1, 1'b1, 1'b0, 5'd0, 32'hAA, 32'h0, 1'b0, 5'd0, 32'h0);
        @(negedge clk);
        check("r0_WR",     64'(bus.WR),     64'd0);
        check("r0_R_dest", 64'(bus.R_dest), 64'd0);
        drive(1'b1, 1'b1, 1'b0, 5'd30, 32'hBB, 32'h0, 1'b0, 5'd0, 32'h0);
        @(negedge clk);
        check("r30_WR",     64'(bus.WR),     64'd0);
        check("r30_R_dest", 64'(bus.R_dest), 64'd30);
        idle();
        @(negedge clk);
        check("filt_retired", 64'(bus.retired), 64'd4);

        // Dual write followed by an ALU op held through the stall.
        drive(1'b1, 1'b1, 1'b1, 5'd7, 32'h0, 32'h11111111, 1'b1, 5'd3, 32'h200);
        @(negedge clk);
        check("hold_pri_stall", 64'(bus.stall_mem), 64'd1);
        drive(1'b1, 1'b1, 1'b0, 5'd9, 32'h99, 32'h0, 1'b0, 5'd0, 32'h0);
        @(negedge clk);
        check("hold_sec_R_dest", 64'(bus.R_dest), 64'd3);
        @(negedge clk);
        check("hold_r9_R_dest", 64'(bus.R_dest), 64'd9);
        check("hold_r9_WR",     64'(bus.WR),     64'd1);
        check("hold_r9_WBData", 64'(bus.WBData), 64'h99);
        idle();
        @(negedge clk);
        check("hold_after_WR",  64'(bus.WR),      64'd0);
        check("hold_retired",   64'(bus.retired), 64'd6);

        // Reset during the second write.
        drive(1'b1, 1'b1, 1'b1, 5'd7, 32'h0, 32'h22222222, 1'b1, 5'd3, 32'h300);
        @(negedge clk);
        idle();
        @(negedge clk);
        check("rsec_R_dest", 64'(bus.R_dest), 64'd3);
        reset = 1'b1;
        @(negedge clk);
        check("rsec_WR",      64'(bus.WR),        64'd0);
        check("rsec_stall",   64'(bus.stall_mem), 64'd0);
        check("rsec_retired", 64'(bus.retired),   64'd0);
        check("rsec_R_dest0", 64'(bus.R_dest),    64'd0);
        reset = 1'b0;
        @(negedge clk);
        check("rsec_after_WR", 64'(bus.WR),      64'd0);
        check("rsec_after_rt", 64'(bus.retired), 64'd0);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 9) < 7), ($urandom_range(0, 19) < 17), $urandom_range(0, 1) == 1,
                  5'($urandom_range(0, 31)), $urandom, $urandom, ($urandom_range(0, 3) == 0),
                  5'($urandom_range(0, 31)), $urandom);
            reset = ($urandom_range(0, 399) == 0);
            @(negedge clk);
        end
        reset = 1'b0;
        idle();
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/wb_sequencer.md
Name: wb_sequencer

Overview:
- Writeback stage of the pipelined core; the writer side of the register file's write port (R_dest/WBData/WR).
- Registers MEM-stage results, selects ALU vs load data, and serialises dual-write instructions (load with base update) onto the single write port, stalling MEM for one cycle.
- Provides a retired-instruction counter.

Parameters:
- DW, 32, data width
- AW, 5, register address width
- PC_REG, 30, register index hardwired to PC; writes to it are suppressed

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high reset
- mem_valid  in  1  MEM stage presents an instruction
- mem_wr_en  in  1  instruction writes a primary destination
- mem_is_load  in  1  primary data comes from mem_load_data, otherwise from mem_result
- mem_rd  in  AW  primary destination
- mem_result  in  DW  ALU result
- mem_load_data  in  DW  data-memory read data
- mem_has_second  in  1  instruction has a second write
- mem_rd2  in  AW  second destination (base register)
- mem_data2  in  DW  second write data (updated base)
- stall_mem  out  1  MEM must hold its instruction this cycle
- R_dest  out  AW  register-file write address
- WBData  out  DW  register-file write data
- WR  out  1  register-file write enable
- retired  out  32  count of completed instructions
- fwd_valid, fwd_dest, fwd_data  out  1/AW/DW  bypass (optional feature)

Behaviour:
- accept = mem_valid & ~stall_mem. Latched at the rising edge.
- Latency: 1 cycle. WR/R_dest/WBData are registered and valid in the cycle after acceptance.
- States:
  - IDLE: no output.
  - PRI: primary write on port.
  - SEC: second write on port.
- Transitions:
  - IDLE → PRI on accept, else stay.
  - PRI with sec_pending → SEC, with no accept possible since stall_mem = 1.
  - PRI without sec_pending → PRI on accept, else IDLE.
  - SEC → PRI on accept, else IDLE.
- stall_mem = (state == PRI) & sec_pending. It is combinational from registered state only and never depends on mem_valid.
- PRI outputs: R_dest = latched rd; WBData = is_load ? load_data : result.
- WR = wr_en & valid & (dest != 0) & (dest != PC_REG). R_dest/WBData are still driven when WR is suppressed.
- SEC outputs: R_dest = rd2, WBData = data2, same WR filter with wr_en treated as 1.
- Instruction with wr_en = 0 and has_second = 1: PRI cycle has WR = 0; SEC still occurs.
- rd2 == rd: both writes issue in order, so the second value lands last.
- retired increments by 1 on the final cycle of each instruction: PRI without second, or SEC. Suppressed writes still count. Wraps from 0xFFFFFFFF to 0.
- Back-to-back single writes: one per cycle, no bubbles.
- Reset (any state, including mid-SEC): state IDLE, WR = 0, R_dest = 0, WBData = 0, stall_mem = 0, retired = 0, fwd_* = 0. A pending second write is discarded.

Optional Feature:
- Macro WB_FWD_EN.
- Defined: fwd_valid = WR, fwd_dest = R_dest, fwd_data = WBData in the same cycle, for the ID-stage bypass mux.
- Undefined: fwd_* tied to 0, no extra logic.

Decomposition:
- Shared package holds:
  - wb_state_t enum (IDLE, PRI, SEC)
  - REG_ZERO = 0, REG_PC = 30
  - DW/AW defaults
- No sub-module is needed; the write-filter (dest != 0/30) is a small function in the package, reusable by the hazard unit.

Test Plan:
- Single ALU op: mem_rd = 5, mem_result = 0x1234, accept at cycle 0 → cycle 1: WR = 1, R_dest = 5, WBData = 0x1234; retired = 1 afterwards.
- Load with base update: rd = 7, load_data = 0xDEADBEEF, rd2 = 3, data2 = 0x104 → cycle 1: stall_mem = 1, write r7 = 0xDEADBEEF; cycle 2: stall_mem = 0, write r3 = 0x104; retired +1 only.
- Filtered writes: rd = 0, then rd = 30 → WR = 0 both cycles, R_dest shows 0/30, retired +2.
- Back-to-back with held MEM: dual-write followed by ALU op rd = 9 held during stall → r9 written exactly once, in cycle 3.
- Reset mid-SEC: assert reset in the SEC cycle → next cycle WR = 0, stall_mem = 0, retired = 0; the second write never appears.
- WB_FWD_EN defined: fwd_* equal WR/R_dest/WBData every cycle. Undefined: fwd_* constant 0.
